// File: rtl/mdsa_phase_ctrl.sv
// Phase sequencer for the N x N row/column odd-even sorter array (shear-sort order).
// Drives en/start/trans/dir for the datapath and reports completion to the host.
module mdsa_phase_ctrl #(
    parameter int unsigned N          = 8,
    parameter int unsigned SORT_LAT   = 8,
    parameter int unsigned NUM_PHASES = 7,
    localparam int unsigned PW        = $clog2(NUM_PHASES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          abort,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] phase_idx,
    output logic          sorter_en,
    output logic          sorter_start,
    output logic          sorter_trans,
    output logic [N-1:0]  sorter_dir
);

    localparam int unsigned LW = $clog2(SORT_LAT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [LW-1:0] LAT_LAST = LW'(SORT_LAT - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(NUM_PHASES - 1);

    // Row phases use the snake pattern (odd rows descending); column phases all ascending.
    function automatic logic [N-1:0] dir_for(input logic [PW-1:0] ph);
        logic [N-1:0] d;
        d = '0;
        if (!ph[0]) begin
            for (int unsigned i = 0; i < N; i++) begin
                d[i] = i[0];
            end
        end
        return d;
    endfunction

    logic [2:0]    state;
    logic [2:0]    state_n;
    logic [LW-1:0] lat_cnt;
    logic [LW-1:0] lat_n;
    logic [PW-1:0] phase_n;
    logic [N-1:0]  dir_n;
    logic          busy_n;

    always_comb begin
        state_n = state;
        lat_n   = lat_cnt;
        phase_n = phase_idx;
        dir_n   = sorter_dir;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_n = S_LOAD;
                    lat_n   = '0;
                    phase_n = '0;
                    dir_n   = dir_for(PW'(0));
                end
            end
            S_LOAD: begin
                state_n = S_WAIT;
                lat_n   = '0;
            end
            S_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_n = S_CAPT;
                end else begin
                    lat_n = lat_cnt + LW'(1);
                end
            end
            S_CAPT: begin
                if (phase_idx == PH_LAST) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_WAIT;
                    lat_n   = '0;
                    phase_n = phase_idx + PW'(1);
                    dir_n   = dir_for(phase_idx + PW'(1));
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                phase_n = '0;
                dir_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                lat_n   = '0;
                phase_n = '0;
                dir_n   = '0;
            end
        endcase

        // Abort only cancels a running sort; a DONE pulse always completes.
        if (abort && (state == S_LOAD || state == S_WAIT || state == S_CAPT)) begin
            state_n = S_IDLE;
            lat_n   = '0;
            phase_n = '0;
            dir_n   = '0;
        end

        busy_n = (state_n == S_LOAD) || (state_n == S_WAIT) || (state_n == S_CAPT);
    end

    // Outputs are registered from the next-state decode so every pin comes from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            lat_cnt      <= '0;
            phase_idx    <= '0;
            sorter_dir   <= '0;
            ready        <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            sorter_en    <= 1'b0;
            sorter_start <= 1'b0;
            sorter_trans <= 1'b0;
        end else begin
            state        <= state_n;
            lat_cnt      <= lat_n;
            phase_idx    <= phase_n;
            sorter_dir   <= dir_n;
            ready        <= (state_n == S_IDLE);
            busy         <= busy_n;
            done         <= (state_n == S_DONE);
            sorter_en    <= busy_n;
            sorter_start <= (state_n == S_LOAD);
            sorter_trans <= (state_n == S_LOAD) || (state_n == S_CAPT);
        end
    end

endmodule
